// File: rtl/prog_ctr.sv
// Program counter and fetch sequencer for the 3BC processor.
// Owns the Start/Done run handshake and a saturating run-length cycle counter.
module prog_ctr #(
    parameter int PC_W = 10,
    parameter int CT_W = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            BranchAbs,
    input  logic            BranchRel,
    input  logic            Taken,
    input  logic [PC_W-1:0] Target,
    input  logic            Stall,
    input  logic            Halt,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Done,
    output logic [CT_W-1:0] CycleCt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [PC_W-1:0] next_pc;

    // Target is two's complement for relative branches, so a plain modular add covers both directions.
    always_comb begin
        next_pc = ProgCtr;
        if (Stall) begin
            next_pc = ProgCtr;
        end else if (BranchAbs && Taken) begin
            next_pc = Target;
        end else if (BranchRel && Taken) begin
            next_pc = ProgCtr + Target;
        end else begin
            next_pc = ProgCtr + PC_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            ProgCtr <= '0;
            Done    <= 1'b0;
            CycleCt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state   <= S_LOAD;
                        ProgCtr <= StartAddr;
                        CycleCt <= '0;
                        Done    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (Start) begin
                        ProgCtr <= StartAddr;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (Start) begin
                        state   <= S_LOAD;
                        ProgCtr <= StartAddr;
                        CycleCt <= '0;
                        Done    <= 1'b0;
                    end else begin
                        // Every RUN edge counts, including stall and halt edges.
                        if (CycleCt != '1) begin
                            CycleCt <= CycleCt + CT_W'(1);
                        end
                        if (Halt) begin
                            state <= S_DONE;
                            Done  <= 1'b1;
                        end else begin
                            ProgCtr <= next_pc;
                        end
                    end
                end
                S_DONE: begin
                    if (Start) begin
                        state   <= S_LOAD;
                        ProgCtr <= StartAddr;
                        CycleCt <= '0;
                        Done    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ctr.sv
// Scoreboard bench for prog_ctr: driver queues hand-computed results, monitor checks them.
// A second instance with a 4-bit cycle counter shares all inputs to exercise saturation.
module tb_prog_ctr;

    logic       Clk = 1'b0;
    logic       Reset, Start, BranchAbs, BranchRel, Taken, Stall, Halt;
    logic [9:0] StartAddr, Target;
    logic [9:0] ProgCtr, ProgCtrS;
    logic       Done, DoneS;
    logic [15:0] CycleCt;
    logic [3:0]  CycleCtS;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [9:0]  pc;
        logic        done;
        logic [15:0] cyc;
        logic [3:0]  cyc_s;
    } exp_t;

    exp_t sb[$];

    always #5 Clk = ~Clk;

    prog_ctr #(.PC_W(10), .CT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .BranchAbs(BranchAbs), .BranchRel(BranchRel), .Taken(Taken),
        .Target(Target), .Stall(Stall), .Halt(Halt),
        .ProgCtr(ProgCtr), .Done(Done), .CycleCt(CycleCt)
    );

    prog_ctr #(.PC_W(10), .CT_W(4)) dut_s (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .BranchAbs(BranchAbs), .BranchRel(BranchRel), .Taken(Taken),
        .Target(Target), .Stall(Stall), .Halt(Halt),
        .ProgCtr(ProgCtrS), .Done(DoneS), .CycleCt(CycleCtS)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every edge the DUT presents new registered outputs; compare with the queued entry.
    always @(posedge Clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, " pc"},     {6'd0, ProgCtr},  {6'd0, e.pc});
            check({e.name, " done"},   {15'd0, Done},    {15'd0, e.done});
            check({e.name, " cyc"},    CycleCt,          e.cyc);
            check({e.name, " cyc4"},   {12'd0, CycleCtS}, {12'd0, e.cyc_s});
            check({e.name, " pc4"},    {6'd0, ProgCtrS}, {6'd0, e.pc});
        end
    end

    // Drive one cycle of inputs at the falling edge and queue the expected post-edge outputs.
    task automatic apply_cycle(
        input string name,
        input logic rst, input logic st, input logic [9:0] sa,
        input logic babs, input logic brel, input logic tk, input logic [9:0] tgt,
        input logic stl, input logic hlt,
        input logic [9:0] pc, input logic dn, input logic [15:0] cyc, input logic [3:0] cyc_s
    );
        exp_t e;
        @(negedge Clk);
        Reset = rst; Start = st; StartAddr = sa;
        BranchAbs = babs; BranchRel = brel; Taken = tk; Target = tgt;
        Stall = stl; Halt = hlt;
        e.name = name; e.pc = pc; e.done = dn; e.cyc = cyc; e.cyc_s = cyc_s;
        sb.push_back(e);
        @(posedge Clk);
    endtask

    task automatic plain(input string name, input logic [9:0] pc, input logic [15:0] cyc, input logic [3:0] cyc_s);
        apply_cycle(name, 0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, pc, 0, cyc, cyc_s);
    endtask

    task automatic load(input string name, input logic [9:0] addr);
        apply_cycle({name, " load"}, 0, 1, addr, 0, 0, 0, 10'h000, 0, 0, addr, 0, 0, 0);
        apply_cycle({name, " run"},  0, 0, 10'h3AA, 0, 0, 0, 10'h000, 0, 0, addr, 0, 0, 0);
    endtask

    initial begin
        Reset = 1; Start = 0; StartAddr = 0; BranchAbs = 0; BranchRel = 0;
        Taken = 0; Target = 0; Stall = 0; Halt = 0;

        apply_cycle("reset", 1, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 0);
        apply_cycle("idle ignores branch", 0, 0, 10'h000, 1, 0, 1, 10'h155, 0, 0, 10'h000, 0, 0, 0);

        apply_cycle("start1", 0, 1, 10'h010, 0, 0, 0, 10'h000, 0, 0, 10'h010, 0, 0, 0);
        apply_cycle("start2", 0, 1, 10'h010, 0, 0, 0, 10'h000, 0, 0, 10'h010, 0, 0, 0);
        apply_cycle("to run", 0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 10'h010, 0, 0, 0);
        plain("seq1", 10'h011, 1, 1);
        plain("seq2", 10'h012, 2, 2);
        plain("seq3", 10'h013, 3, 3);

        load("rel", 10'h020);
        apply_cycle("rel taken", 0, 0, 10'h000, 0, 1, 1, 10'h3F0, 0, 0, 10'h010, 0, 1, 1);
        load("rel nt", 10'h020);
        apply_cycle("rel not taken", 0, 0, 10'h000, 0, 1, 0, 10'h3F0, 0, 0, 10'h021, 0, 1, 1);

        load("abs", 10'h005);
        apply_cycle("abs wins", 0, 0, 10'h000, 1, 1, 1, 10'h003, 0, 0, 10'h003, 0, 1, 1);
        load("wrap", 10'h3FF);
        plain("wrap", 10'h000, 1, 1);

        load("stall", 10'h040);
        apply_cycle("stall1", 0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 0, 10'h040, 0, 1, 1);
        apply_cycle("stall2", 0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 0, 10'h040, 0, 2, 2);
        plain("stall release", 10'h041, 3, 3);

        load("halt", 10'h050);
        apply_cycle("halt", 0, 0, 10'h000, 1, 0, 1, 10'h111, 1, 1, 10'h050, 1, 1, 1);
        apply_cycle("done hold", 0, 0, 10'h000, 1, 0, 1, 10'h111, 0, 0, 10'h050, 1, 1, 1);
        apply_cycle("restart", 0, 1, 10'h000, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 0);

        load("mid reset", 10'h123);
        apply_cycle("mid reset", 1, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 0);
        plain("idle after reset", 10'h000, 0, 0);

        load("sat", 10'h000);
        for (int k = 1; k <= 20; k++) begin
            plain("sat", 10'(k), 16'(k), (k > 15) ? 4'hF : 4'(k));
        end
        apply_cycle("start beats halt", 0, 1, 10'h200, 0, 0, 0, 10'h000, 0, 1, 10'h200, 0, 0, 0);

        @(posedge Clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: %0d left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
